// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and
// holds each instruction for decode until it retires.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_branch, pc_jump, next_pc;

  // Targets are word-aligned by construction, so pc[1:0] stays 00.
  always_comb begin
    pcplus4   = pc_q + 32'd4;
    pc_branch = pcplus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    pc_jump   = {pcplus4[31:28], instr_q[25:0], 2'b00};
    if (jump) begin
      next_pc = pc_jump;
    end else if (branch && zero) begin
      next_pc = pc_branch;
    end else begin
      next_pc = pcplus4;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    req_d     = req_q;
    valid_d   = valid_q;
    unique case (state_q)
      StIdle: begin
        req_d   = 1'b1;
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = StValid;
        end
      end
      StValid: begin
        if (instr_ready) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          valid_d   = 1'b0;
          req_d     = 1'b1;
          state_d   = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for stalls/reset/wrap,
// and randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pcplus4, retired;

  // Shared stimulus for the two instances with non-zero reset PCs.
  logic        a_reset = 1'b1;
  logic        a_ack = 1'b0;
  logic [31:0] a_rdata = 32'h0;
  logic        a_ready = 1'b0;
  logic        a_branch = 1'b0;
  logic        a_zero = 1'b0;
  logic        w_jump = 1'b0;
  logic        h_jump = 1'b0;
  logic        w_req, w_valid, h_req, h_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_ret;
  logic [31:0] h_addr, h_instr, h_pc, h_pc4, h_ret;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch(branch), .zero(zero), .jump(jump), .pc(pc),
    .pcplus4(pcplus4), .retired(retired)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(a_reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(a_ack), .imem_rdata(a_rdata), .instr(w_instr), .instr_valid(w_valid),
    .instr_ready(a_ready), .branch(a_branch), .zero(a_zero), .jump(w_jump), .pc(w_pc),
    .pcplus4(w_pc4), .retired(w_ret)
  );

  fetch_unit #(.RESET_PC(32'h1000_0000)) u_hi (
    .clk(clk), .reset(a_reset), .imem_req(h_req), .imem_addr(h_addr),
    .imem_ack(a_ack), .imem_rdata(a_rdata), .instr(h_instr), .instr_valid(h_valid),
    .instr_ready(a_ready), .branch(a_branch), .zero(a_zero), .jump(h_jump), .pc(h_pc),
    .pcplus4(h_pc4), .retired(h_ret)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic        zr;
    logic        jp;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ret;
  } vec_t;

  vec_t tbl [20];

  // Reference model: tracks whether a fetch is outstanding or an instruction is held.
  logic [31:0] m_pc, m_instr, m_ret;
  logic        m_req, m_valid;

  function automatic logic [31:0] target(input logic [31:0] cur_pc, input logic [31:0] ins,
                                         input logic b, input logic z, input logic j);
    logic [31:0] seq;
    logic [15:0] imm;
    int          off;
    seq = cur_pc + 32'd4;
    imm = ins[15:0];
    off = int'($signed(imm));
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b && z) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ret = 32'h0; m_req = 1'b0; m_valid = 1'b0;
    end else if (!m_req && !m_valid) begin
      m_req = 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_valid = 1'b1; m_req = 1'b0;
      end
    end else if (instr_ready) begin
      m_pc = target(m_pc, m_instr, branch, zero, jump);
      m_ret = m_ret + 32'd1; m_valid = 1'b0; m_req = 1'b1;
    end
  endtask

  initial begin
    // rst ack rdata rdy br zr jp | req addr valid instr retired
    tbl[0]  = '{1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,  0, 32'h0,         0};
    tbl[1]  = '{0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 1, 32'h0,  0, 32'h0,         0};
    tbl[2]  = '{0, 1, 32'h0000_0011, 1, 0, 0, 0, 0, 32'h0,  1, 32'h0000_0011, 0};
    tbl[3]  = '{0, 1, 32'h0000_0022, 1, 0, 0, 0, 1, 32'h4,  0, 32'h0000_0011, 1};
    tbl[4]  = '{0, 1, 32'h0000_0022, 1, 0, 0, 0, 0, 32'h4,  1, 32'h0000_0022, 1};
    tbl[5]  = '{0, 1, 32'h0000_0033, 1, 0, 0, 0, 1, 32'h8,  0, 32'h0000_0022, 2};
    tbl[6]  = '{0, 1, 32'h0000_0033, 1, 0, 0, 0, 0, 32'h8,  1, 32'h0000_0033, 2};
    tbl[7]  = '{0, 1, 32'h0800_0010, 1, 0, 0, 0, 1, 32'hC,  0, 32'h0000_0033, 3};
    tbl[8]  = '{0, 1, 32'h0800_0010, 1, 0, 0, 1, 0, 32'hC,  1, 32'h0800_0010, 3};
    tbl[9]  = '{0, 1, 32'h1000_0003, 1, 0, 0, 1, 1, 32'h40, 0, 32'h0800_0010, 4};
    tbl[10] = '{0, 1, 32'h1000_0003, 1, 1, 1, 0, 0, 32'h40, 1, 32'h1000_0003, 4};
    tbl[11] = '{0, 1, 32'h0800_0010, 1, 1, 1, 0, 1, 32'h50, 0, 32'h1000_0003, 5};
    tbl[12] = '{0, 1, 32'h0800_0010, 1, 0, 0, 1, 0, 32'h50, 1, 32'h0800_0010, 5};
    tbl[13] = '{0, 1, 32'h1000_0003, 1, 0, 0, 1, 1, 32'h40, 0, 32'h0800_0010, 6};
    tbl[14] = '{0, 1, 32'h1000_0003, 1, 1, 0, 0, 0, 32'h40, 1, 32'h1000_0003, 6};
    tbl[15] = '{0, 1, 32'h0800_0002, 1, 1, 0, 0, 1, 32'h44, 0, 32'h1000_0003, 7};
    tbl[16] = '{0, 1, 32'h0800_0002, 1, 0, 0, 1, 0, 32'h44, 1, 32'h0800_0002, 7};
    tbl[17] = '{0, 1, 32'h1000_FFFF, 1, 0, 0, 1, 1, 32'h8,  0, 32'h0800_0002, 8};
    tbl[18] = '{0, 1, 32'h1000_FFFF, 1, 1, 1, 0, 0, 32'h8,  1, 32'h1000_FFFF, 8};
    tbl[19] = '{0, 1, 32'h0,         1, 1, 1, 0, 1, 32'h8,  0, 32'h1000_FFFF, 9};

    #1;
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
      instr_ready = tbl[i].rdy; branch = tbl[i].br; zero = tbl[i].zr; jump = tbl[i].jp;
      step();
      check($sformatf("vec%0d req", i), imem_req, tbl[i].e_req);
      check($sformatf("vec%0d addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("vec%0d valid", i), instr_valid, tbl[i].e_valid);
      check($sformatf("vec%0d instr", i), instr, tbl[i].e_instr);
      check($sformatf("vec%0d retired", i), retired, tbl[i].e_ret);
    end

    // Slow memory: address held, nothing valid until ack.
    imem_ack = 0; instr_ready = 1; branch = 0; zero = 0; jump = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("ack_wait addr", imem_addr, 32'h8);
      check("ack_wait req", imem_req, 1'b1);
      check("ack_wait valid", instr_valid, 1'b0);
    end
    imem_ack = 1; imem_rdata = 32'hABCD_0001; instr_ready = 0;
    step();
    check("late_ack valid", instr_valid, 1'b1);
    check("late_ack instr", instr, 32'hABCD_0001);
    // Decode stall with spurious acks arriving.
    imem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 7; i++) begin
      step();
      check("stall instr", instr, 32'hABCD_0001);
      check("stall pc", pc, 32'h8);
      check("stall valid", instr_valid, 1'b1);
      check("stall retired", retired, 32'd9);
      check("stall req", imem_req, 1'b0);
    end
    imem_ack = 0; instr_ready = 1;
    step();
    check("stall_release addr", imem_addr, 32'hC);
    check("stall_release retired", retired, 32'd10);
    check("stall_release valid", instr_valid, 1'b0);
    imem_ack = 1; imem_rdata = 32'h0800_0008; instr_ready = 0;
    step();
    imem_ack = 0; instr_ready = 1; jump = 1;
    step();
    check("to_0x20 addr", imem_addr, 32'h20);
    check("to_0x20 req", imem_req, 1'b1);

    // Reset while fetching, then an ack straight after reset.
    reset = 1; jump = 0; instr_ready = 0;
    step();
    check("midreset req", imem_req, 1'b0);
    check("midreset addr", imem_addr, 32'h0);
    check("midreset instr", instr, 32'h0);
    check("midreset retired", retired, 32'h0);
    reset = 0; imem_ack = 1; imem_rdata = 32'h1234_5678;
    step();
    check("post_reset req", imem_req, 1'b1);
    check("post_reset addr", imem_addr, 32'h0);
    check("post_reset instr", instr, 32'h0);
    imem_ack = 0;
    step();
    check("post_reset2 instr", instr, 32'h0);
    check("post_reset2 valid", instr_valid, 1'b0);

    // Wrap-around and jump-region instances.
    a_reset = 1;
    step();
    check("wrap reset addr", w_addr, 32'hFFFF_FFFC);
    check("hi reset addr", h_addr, 32'h1000_0000);
    check("wrap reset req", w_req, 1'b0);
    a_reset = 0; a_ack = 1; a_rdata = 32'h0800_0010; a_ready = 1; h_jump = 1;
    step();
    check("wrap fetch req", w_req, 1'b1);
    step();
    check("wrap valid", w_valid, 1'b1);
    check("wrap pcplus4", w_pc4, 32'h0);
    step();
    check("wrap next addr", w_addr, 32'h0);
    check("hi jump addr", h_addr, 32'h1000_0040);
    check("wrap retired", w_ret, 32'd1);
    a_branch = 1; a_zero = 1;
    step();
    step();
    check("hi jump_over_branch addr", h_addr, 32'h1000_0040);
    check("wrap branch addr", w_addr, 32'h44);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      reset = (i == 0) || ($urandom_range(0, 79) == 0);
      imem_ack = ($urandom_range(0, 2) != 0);
      imem_rdata = $urandom;
      instr_ready = $urandom_range(0, 1);
      branch = $urandom_range(0, 1);
      zero = $urandom_range(0, 1);
      jump = ($urandom_range(0, 3) == 0);
      model_step();
      step();
      check("rand req", imem_req, m_req);
      check("rand valid", instr_valid, m_valid);
      check("rand addr", imem_addr, m_pc);
      check("rand pc", pc, m_pc);
      check("rand pcplus4", pcplus4, m_pc + 32'd4);
      check("rand instr", instr, m_instr);
      check("rand retired", retired, m_ret);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
